nrzi_rx_deser: RTL and testbench

//   Receive end of the toggle-coded (NRZI) serial link whose transmitter is built from T flip-flops:
//   a line toggle means bit 1, no toggle means bit 0.

---
 rtl/nrzi_pkg.sv | 18 +
 rtl/nrzi_bit_decoder.sv | 33 +++
 rtl/nrzi_rx_deser.sv | 154 +++++++++++++++
 tb/tb_nrzi_rx_deser.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/nrzi_pkg.sv
// Package shared by the NRZI receive path.
//   state_t       : deserializer FSM states (HUNT for sync, DATA inside a frame)
//   DEF_*         : default link constants (word width, words per frame,
//                   sync width/pattern, zero-run length that forces a stuffed 1)
package nrzi_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

  localparam int             DEF_DATA_W  = 8;
  localparam int             DEF_NWORDS  = 4;
  localparam int             DEF_SYNC_W  = 8;
  localparam logic [7:0]     DEF_SYNC    = 8'hD5;
  localparam int             DEF_MAX_RUN = 6;

endpackage

// File: rtl/nrzi_bit_decoder.sv
// NRZI line decoder: the inverse of the transmitter's T flip-flop.
// A change of line level since the previous valid sample decodes as 1,
// no change decodes as 0.
//   clk       in   rising-edge clock
//   rst       in   synchronous, active-low reset (line assumed idle low)
//   bit_en    in   line sample valid this cycle
//   nrzi_in   in   sampled line level
//   line_bit  out  decoded bit for the current sample (combinational)
//   bit_vld   out  line_bit is meaningful this cycle
module nrzi_bit_decoder (
  input  logic clk,
  input  logic rst,
  input  logic bit_en,
  input  logic nrzi_in,
  output logic line_bit,
  output logic bit_vld
);

  logic prev_line_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_line_reg <= 1'b0;
    end else if (bit_en) begin
      prev_line_reg <= nrzi_in;
    end
  end

  // Decoded bit is used by the FSM on the same edge that stores the new level.
  assign line_bit = nrzi_in ^ prev_line_reg;
  assign bit_vld  = bit_en;

endmodule

// File: rtl/nrzi_rx_deser.sv
// NRZI receive deserializer.
// Decodes the toggle-coded line, hunts for the sync word, removes stuffed
// bits and assembles LSB-first words. After NWORDS words the frame ends
// and the block returns to hunting for sync.
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-low reset
//   bit_en      in   line sample valid; all state holds when 0
//   nrzi_in     in   sampled line level
//   data_out    out  last completed word, held until the next one
//   data_valid  out  1-cycle pulse, data_out updated
//   frame_done  out  1-cycle pulse with the last word of a frame
//   stuff_err   out  1-cycle pulse, zero run too long inside a frame
//   in_frame    out  1 while the FSM is in DATA
module nrzi_rx_deser
  import nrzi_pkg::*;
#(
  parameter int                DATA_W  = DEF_DATA_W,   // >= 3
  parameter int                NWORDS  = DEF_NWORDS,   // >= 1
  parameter int                SYNC_W  = DEF_SYNC_W,   // >= 3
  parameter logic [SYNC_W-1:0] SYNC    = DEF_SYNC,
  parameter int                MAX_RUN = DEF_MAX_RUN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              nrzi_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_done,
  output logic              stuff_err,
  output logic              in_frame
);

  localparam int BCNT_W = $clog2(DATA_W + 1);
  localparam int WCNT_W = $clog2(NWORDS + 1);
  localparam int RCNT_W = $clog2(MAX_RUN + 1);

  logic line_bit;
  logic bit_vld;

  nrzi_bit_decoder u_dec (
    .clk      (clk),
    .rst      (rst),
    .bit_en   (bit_en),
    .nrzi_in  (nrzi_in),
    .line_bit (line_bit),
    .bit_vld  (bit_vld)
  );

  state_t              state_reg;
  // Both shift registers keep one bit fewer than their full width: the newest
  // bit comes straight from the decoder and completes the window/word.
  logic [SYNC_W-2:0]   hunt_reg;
  logic [DATA_W-2:0]   shreg_reg;
  logic [BCNT_W-1:0]   bit_cnt_reg;
  logic [WCNT_W-1:0]   word_cnt_reg;
  logic [RCNT_W-1:0]   run_cnt_reg;
  logic [DATA_W-1:0]   data_out_reg;
  logic                data_valid_reg;
  logic                frame_done_reg;
  logic                stuff_err_reg;

  logic [SYNC_W-1:0]   hunt_window;
  logic [DATA_W-1:0]   word_next;
  logic                run_at_max;
  logic                last_bit;
  logic                last_word;

  assign hunt_window = {line_bit, hunt_reg};
  assign word_next   = {line_bit, shreg_reg};
  assign run_at_max  = (run_cnt_reg  == RCNT_W'(MAX_RUN));
  assign last_bit    = (bit_cnt_reg  == BCNT_W'(DATA_W - 1));
  assign last_word   = (word_cnt_reg == WCNT_W'(NWORDS - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= HUNT;
      hunt_reg       <= '0;
      shreg_reg      <= '0;
      bit_cnt_reg    <= '0;
      word_cnt_reg   <= '0;
      run_cnt_reg    <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      frame_done_reg <= 1'b0;
      stuff_err_reg  <= 1'b0;
    end else begin
      // Pulses last exactly one cycle and only follow a valid sample.
      data_valid_reg <= 1'b0;
      frame_done_reg <= 1'b0;
      stuff_err_reg  <= 1'b0;

      if (bit_vld) begin
        case (state_reg)
          HUNT: begin
            if (hunt_window == SYNC) begin
              state_reg    <= DATA;
              hunt_reg     <= '0;
              bit_cnt_reg  <= '0;
              word_cnt_reg <= '0;
              run_cnt_reg  <= '0;
            end else begin
              hunt_reg <= hunt_window[SYNC_W-1:1];
            end
          end

          DATA: begin
            if (run_at_max) begin
              if (line_bit) begin
                // Stuffed 1: drop it, it does not count as data.
                run_cnt_reg <= '0;
              end else begin
                // Transmitter failed to stuff: abandon the frame.
                stuff_err_reg <= 1'b1;
                state_reg     <= HUNT;
                bit_cnt_reg   <= '0;
                word_cnt_reg  <= '0;
                run_cnt_reg   <= '0;
              end
            end else begin
              // Zero runs carry across word boundaries inside a frame.
              run_cnt_reg <= line_bit ? '0 : run_cnt_reg + RCNT_W'(1);
              if (last_bit) begin
                bit_cnt_reg    <= '0;
                data_out_reg   <= word_next;
                data_valid_reg <= 1'b1;
                if (last_word) begin
                  frame_done_reg <= 1'b1;
                  state_reg      <= HUNT;
                  word_cnt_reg   <= '0;
                  run_cnt_reg    <= '0;
                end else begin
                  word_cnt_reg <= word_cnt_reg + WCNT_W'(1);
                end
              end else begin
                shreg_reg   <= word_next[DATA_W-1:1];
                bit_cnt_reg <= bit_cnt_reg + BCNT_W'(1);
              end
            end
          end

          default: state_reg <= HUNT;
        endcase
      end
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign frame_done = frame_done_reg;
  assign stuff_err  = stuff_err_reg;
  assign in_frame   = (state_reg == DATA);

endmodule

// File: tb/tb_nrzi_rx_deser.sv
// Directed bench for nrzi_rx_deser. A T flip-flop transmitter model with
// zero-run stuffing drives the line; expected words are hand-chosen constants.
module tb_nrzi_rx_deser;

  logic       clk;
  logic       rst;
  logic       bit_en;
  logic       nrzi_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_done;
  logic       stuff_err;
  logic       in_frame;

  nrzi_rx_deser dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .nrzi_in    (nrzi_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_done (frame_done),
    .stuff_err  (stuff_err),
    .in_frame   (in_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // transmitter model state
  logic line     = 1'b0;
  int   tx_run   = 0;
  int   pos_bad  = 0;   // data_valid seen/missing at the wrong bit position
  int   max_gap  = 0;

  // pulse monitor
  logic [7:0] got_q[$];
  logic       fd_q[$];
  int         n_err   = 0;
  int         orphan  = 0;
  int         stretch = 0;
  logic       prev_dv = 1'b0;

  always @(negedge clk) begin
    if (data_valid) begin
      got_q.push_back(data_out);
      fd_q.push_back(frame_done);
      $display("  word 0x%02h frame_done=%0d", data_out, frame_done);
    end
    if (frame_done && !data_valid) orphan++;
    if (stuff_err) n_err++;
    if (data_valid && prev_dv) stretch++;
    prev_dv = data_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    bit_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One line sample carrying decoded bit b, optionally preceded by a gap.
  task automatic send_bit(input logic b);
    if (max_gap > 0) begin
      bit_en = 1'b0;
      repeat ($urandom_range(1, max_gap)) @(posedge clk);
      #1;
    end
    line    = line ^ b;
    nrzi_in = line;
    bit_en  = 1'b1;
    @(posedge clk);
    #1;
    bit_en  = 1'b0;
  endtask

  task automatic send_raw_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic tx_start();
    send_raw_byte(8'hD5);
    tx_run = 0;
  endtask

  // Sends nbits of w LSB first with stuffing; checks that data_valid fires
  // exactly on the 8th real bit of the word and never on a stuffed bit.
  task automatic tx_word(input logic [7:0] w, input bit is_last, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      send_bit(w[i]);
      if (data_valid !== (i == 7)) pos_bad++;
      tx_run = w[i] ? 0 : tx_run + 1;
      if (tx_run == 6 && !(is_last && i == 7)) begin
        send_bit(1'b1);
        if (data_valid !== 1'b0) pos_bad++;
        tx_run = 0;
      end
    end
  endtask

  logic last_fd, last_if;

  task automatic send_frame(input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input logic [7:0] w3);
    tx_start();
    check("sync in_frame", in_frame, 1'b1);
    tx_word(w0, 1'b0, 8);
    tx_word(w1, 1'b0, 8);
    tx_word(w2, 1'b0, 8);
    tx_word(w3, 1'b1, 8);
    last_fd = frame_done;
    last_if = in_frame;
  endtask

  task automatic check_frame(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] w2, input logic [7:0] w3, input int err_exp);
    logic [7:0] exp_w[4];
    exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2; exp_w[3] = w3;
    idle(2);
    check({tag, " count"}, got_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s word%0d", tag, i), (i < got_q.size()) ? got_q[i] : 8'hxx, exp_w[i]);
      check($sformatf("%s fd%0d", tag, i), (i < fd_q.size()) ? fd_q[i] : 1'bx, (i == 3));
    end
    check({tag, " frame_done at end"}, last_fd, 1'b1);
    check({tag, " in_frame at end"}, last_if, 1'b0);
    check({tag, " valid position"}, pos_bad, 0);
    check({tag, " stuff_err count"}, n_err, err_exp);
    got_q.delete();
    fd_q.delete();
    pos_bad = 0;
    $display("%s: frame %02h %02h %02h %02h checked", tag, w0, w1, w2, w3);
  endtask

  initial begin
    rst     = 1'b0;
    bit_en  = 1'b0;
    nrzi_in = 1'b0;

    // 1: reset with random line activity
    for (int k = 0; k < 2; k++) begin
      bit_en  = 1'b1;
      nrzi_in = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("rst data_out", data_out, 8'h00);
      check("rst data_valid", data_valid, 1'b0);
      check("rst frame_done", frame_done, 1'b0);
      check("rst stuff_err", stuff_err, 1'b0);
      check("rst in_frame", in_frame, 1'b0);
    end
    bit_en  = 1'b0;
    nrzi_in = 1'b0;
    line    = 1'b0;
    rst     = 1'b1;
    idle(2);
    $display("t1: reset checked");

    // 2: basic frame
    send_frame(8'h01, 8'h80, 8'hFF, 8'h3C);
    check_frame("t2", 8'h01, 8'h80, 8'hFF, 8'h3C, 0);

    // 3: long zero runs crossing word boundaries
    send_frame(8'h00, 8'h00, 8'h40, 8'h00);
    check_frame("t3", 8'h00, 8'h00, 8'h40, 8'h00, 0);

    // 4: missing stuffed bit
    tx_start();
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    check("t4 no err at 6th", stuff_err, 1'b0);
    check("t4 in_frame at 6th", in_frame, 1'b1);
    send_bit(1'b0);
    check("t4 stuff_err at 7th", stuff_err, 1'b1);
    check("t4 in_frame at 7th", in_frame, 1'b0);
    send_raw_byte(8'h12);
    send_raw_byte(8'h34);
    idle(2);
    check("t4 no words", got_q.size(), 0);
    check("t4 still hunting", in_frame, 1'b0);
    check("t4 err count", n_err, 1);
    $display("t4: stuff violation checked");

    // 5: test 2 with gaps between bits
    max_gap = 3;
    send_frame(8'h01, 8'h80, 8'hFF, 8'h3C);
    max_gap = 0;
    check_frame("t5", 8'h01, 8'h80, 8'hFF, 8'h3C, 1);

    // 6: reset mid-frame, then a fresh frame
    tx_start();
    tx_word(8'h11, 1'b0, 8);
    tx_word(8'h22, 1'b0, 3);
    rst     = 1'b0;
    bit_en  = 1'b1;
    line    = 1'b0;
    nrzi_in = 1'b0;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
    check("t6 in_frame after rst", in_frame, 1'b0);
    check("t6 data_out after rst", data_out, 8'h00);
    rst = 1'b1;
    idle(2);
    check("t6 partial count", got_q.size(), 1);
    check("t6 partial word0", (got_q.size() > 0) ? got_q[0] : 8'hxx, 8'h11);
    got_q.delete();
    fd_q.delete();
    pos_bad = 0;
    n_err   = 0;
    send_frame(8'hA5, 8'h5A, 8'h00, 8'hC3);
    check_frame("t6", 8'hA5, 8'h5A, 8'h00, 8'hC3, 0);

    check("orphan frame_done", orphan, 0);
    check("stretched pulses", stretch, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
